// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
// Holds the default table geometry, the 2-bit saturating counter
// encoding and the canonical layout of one predictor table entry.
package bp_pkg;

  // Default geometry: 16 entries indexed by word-aligned PC bits.
  localparam int BP_IDX_BITS = 4;
  localparam int BP_PC_W     = 32;
  localparam int BP_TAG_W    = BP_PC_W - BP_IDX_BITS - 2;

  // Two-bit counter states; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_state_e;

  // One table entry at the default geometry.
  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_PC_W-1:0]   target;
    ctr_state_e           ctr;
  } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating branch counter.
// Ports:
//   i_state - current counter state
//   i_taken - resolved branch outcome
//   o_next  - counter state after training on i_taken
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_state_e i_state,
  input  logic       i_taken,
  output ctr_state_e o_next
);

  // Step one state toward the observed outcome, holding at either end
  // so a single anomaly cannot flip a strongly biased branch.
  always_comb begin
    o_next = i_state;
    if (i_taken) begin
      if (i_state != CTR_ST) begin
        o_next = ctr_state_e'(i_state + 2'd1);
      end
    end else begin
      if (i_state != CTR_SNT) begin
        o_next = ctr_state_e'(i_state - 2'd1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with target buffer and 2-bit counters.
// The fetch stage looks up if_pc combinationally; the execute stage
// trains the table with resolved branches and raises flush on a
// mispredict.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   if_valid, if_pc              - fetch lookup request
//   pred_taken, pred_next_pc     - fetch prediction
//   ex_branch, ex_stall          - resolved branch present / EX held
//   ex_pc, ex_taken, ex_target   - resolved branch PC, outcome, target
//   ex_pred_taken/_target        - prediction carried down the pipe
//   flush, redirect_pc           - mispredict squash and correct PC
//   br_count, mp_count           - saturating branch / mispredict counts
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int PC_W     = BP_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_next_pc,
  input  logic            ex_branch,
  input  logic            ex_stall,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     br_count,
  output logic [15:0]     mp_count
);

  localparam int              ENTRIES = 1 << IDX_BITS;
  localparam int              TAG_W   = PC_W - IDX_BITS - 2;
  localparam logic [PC_W-1:0] PC_INC  = PC_W'(4);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];
  ctr_state_e       r_ctr    [ENTRIES];
  logic [15:0]      r_brCount;
  logic [15:0]      r_mpCount;

  logic [IDX_BITS-1:0] w_ifIdx;
  logic [TAG_W-1:0]    w_ifTag;
  logic                w_ifHit;
  logic [IDX_BITS-1:0] w_exIdx;
  logic [TAG_W-1:0]    w_exTag;
  logic                w_exHit;
  logic                w_update;
  ctr_state_e          w_nextCtr;

  // Lookup reads the registered table, so a same-cycle update to the
  // same index is only visible to the following lookup.
  assign w_ifIdx      = if_pc[IDX_BITS+1:2];
  assign w_ifTag      = if_pc[PC_W-1:IDX_BITS+2];
  assign w_ifHit      = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);
  assign pred_taken   = if_valid && w_ifHit && r_ctr[w_ifIdx][1];
  assign pred_next_pc = pred_taken ? r_target[w_ifIdx] : (if_pc + PC_INC);

  assign w_exIdx  = ex_pc[IDX_BITS+1:2];
  assign w_exTag  = ex_pc[PC_W-1:IDX_BITS+2];
  assign w_exHit  = r_valid[w_exIdx] && (r_tag[w_exIdx] == w_exTag);
  assign w_update = ex_branch && !ex_stall;

  // A taken branch whose target differs from the carried prediction is
  // a mispredict even when the direction was right.
  assign flush       = w_update &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + PC_INC);

  assign br_count = r_brCount;
  assign mp_count = r_mpCount;

  sat_counter2 u_satCounter (
    .i_state (r_ctr[w_exIdx]),
    .i_taken (ex_taken),
    .o_next  (w_nextCtr)
  );

  // Table training: hits move the counter (and refresh the target on
  // taken), taken misses allocate at weakly-taken, not-taken misses
  // leave the table alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (w_update) begin
      if (w_exHit) begin
        r_ctr[w_exIdx] <= w_nextCtr;
        if (ex_taken) begin
          r_target[w_exIdx] <= ex_target;
        end
      end else if (ex_taken) begin
        r_valid[w_exIdx]  <= 1'b1;
        r_tag[w_exIdx]    <= w_exTag;
        r_target[w_exIdx] <= ex_target;
        r_ctr[w_exIdx]    <= CTR_WT;
      end
    end
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brCount <= '0;
      r_mpCount <= '0;
    end else begin
      if (w_update && (r_brCount != 16'hFFFF)) begin
        r_brCount <= r_brCount + 16'd1;
      end
      if (flush && (r_mpCount != 16'hFFFF)) begin
        r_mpCount <= r_mpCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table-level model is
// compared against the DUT on every falling edge, and directed
// scenarios add hand-computed literal expectations.
module tb_branch_predictor;

  localparam int IDX = 4;
  localparam int PCW = 32;
  localparam int ENT = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           if_valid;
  logic [PCW-1:0] if_pc;
  logic           pred_taken;
  logic [PCW-1:0] pred_next_pc;
  logic           ex_branch;
  logic           ex_stall;
  logic [PCW-1:0] ex_pc;
  logic           ex_taken;
  logic [PCW-1:0] ex_target;
  logic           ex_pred_taken;
  logic [PCW-1:0] ex_pred_target;
  logic           flush;
  logic [PCW-1:0] redirect_pc;
  logic [15:0]    br_count;
  logic [15:0]    mp_count;

  int nChecks = 0;
  int nPass   = 0;
  bit checkEn = 1'b0;

  // Behavioural model state: one slot per table index.
  bit             mValid [ENT];
  logic [PCW-1:0] mTagOf [ENT];
  logic [PCW-1:0] mTarget[ENT];
  int             mCtr   [ENT];
  int             mBr;
  int             mMp;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(IDX), .PC_W(PCW)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .ex_branch      (ex_branch),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  function automatic int idxOf(logic [PCW-1:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic logic [PCW-1:0] tagOf(logic [PCW-1:0] pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit modelHit(logic [PCW-1:0] pc);
    return mValid[idxOf(pc)] && (mTagOf[idxOf(pc)] == tagOf(pc));
  endfunction

  function automatic bit modelPred();
    return if_valid && modelHit(if_pc) && (mCtr[idxOf(if_pc)] >= 2);
  endfunction

  function automatic logic [PCW-1:0] modelNext();
    return modelPred() ? mTarget[idxOf(if_pc)] : if_pc + 32'd4;
  endfunction

  function automatic bit modelFlush();
    return ex_branch && !ex_stall &&
           ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
  endfunction

  function automatic logic [PCW-1:0] modelRedirect();
    return ex_taken ? ex_target : ex_pc + 32'd4;
  endfunction

  // Model training on each accepted resolution; reset clears it at once.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ENT; k++) begin
        mValid[k] <= 1'b0;
        mCtr[k]   <= 1;
      end
      mBr <= 0;
      mMp <= 0;
    end else if (ex_branch && !ex_stall) begin
      if (mBr < 65535) mBr <= mBr + 1;
      if (modelFlush() && mMp < 65535) mMp <= mMp + 1;
      if (modelHit(ex_pc)) begin
        if (ex_taken) begin
          mCtr[idxOf(ex_pc)]    <= (mCtr[idxOf(ex_pc)] == 3) ? 3 : mCtr[idxOf(ex_pc)] + 1;
          mTarget[idxOf(ex_pc)] <= ex_target;
        end else begin
          mCtr[idxOf(ex_pc)] <= (mCtr[idxOf(ex_pc)] == 0) ? 0 : mCtr[idxOf(ex_pc)] - 1;
        end
      end else if (ex_taken) begin
        mValid[idxOf(ex_pc)]  <= 1'b1;
        mTagOf[idxOf(ex_pc)]  <= tagOf(ex_pc);
        mTarget[idxOf(ex_pc)] <= ex_target;
        mCtr[idxOf(ex_pc)]    <= 2;
      end
    end
  end

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn && !rst) begin
      checkOutput("cmp_pred_taken",   pred_taken,   modelPred());
      checkOutput("cmp_pred_next_pc", pred_next_pc, modelNext());
      checkOutput("cmp_flush",        flush,        modelFlush());
      checkOutput("cmp_redirect_pc",  redirect_pc,  modelRedirect());
      checkOutput("cmp_br_count",     br_count,     mBr);
      checkOutput("cmp_mp_count",     mp_count,     mMp);
    end
  end

  task automatic applyStimulus(input logic ifv, input logic [PCW-1:0] ifpc,
                               input logic br, input logic stall,
                               input logic [PCW-1:0] pc, input logic tk,
                               input logic [PCW-1:0] tgt, input logic ptk,
                               input logic [PCW-1:0] ptgt);
    if_valid       = ifv;
    if_pc          = ifpc;
    ex_branch      = br;
    ex_stall       = stall;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic lookupOnly(input logic ifv, input logic [PCW-1:0] ifpc);
    applyStimulus(ifv, ifpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit expPred [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit outcome [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    lookupOnly(1'b1, 32'h100);
    rst = 1'b1;
    repeat (2) tick();

    // Outputs while reset is held.
    midCycle();
    checkOutput("rst_pred_taken", pred_taken, 0);
    checkOutput("rst_next_pc", pred_next_pc, 32'h104);
    checkOutput("rst_br_count", br_count, 0);
    checkOutput("rst_mp_count", mp_count, 0);
    tick();
    rst     = 1'b0;
    checkEn = 1'b1;

    // Cold lookup after reset.
    midCycle();
    checkOutput("cold_pred_taken", pred_taken, 0);
    checkOutput("cold_next_pc", pred_next_pc, 32'h104);

    // First taken branch at 0x100 mispredicts and allocates.
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    midCycle();
    checkOutput("alloc_flush", flush, 1);
    checkOutput("alloc_redirect", redirect_pc, 32'h200);
    tick();
    lookupOnly(1'b1, 32'h100);
    midCycle();
    checkOutput("alloc_pred_taken", pred_taken, 1);
    checkOutput("alloc_next_pc", pred_next_pc, 32'h200);
    checkOutput("alloc_br_count", br_count, 1);
    checkOutput("alloc_mp_count", mp_count, 1);

    // Counter walk: WT -> ST,ST,ST -> WT,WNT,SNT,SNT.
    for (int k = 0; k < 7; k++) begin
      tick();
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, outcome[k], 32'h200, 1'b1, 32'h200);
      tick();
      lookupOnly(1'b1, 32'h100);
      midCycle();
      checkOutput($sformatf("walk_pred_%0d", k), pred_taken, expPred[k]);
    end

    // Stalled mispredicting resolution is ignored.
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
    midCycle();
    checkOutput("stall_flush", flush, 0);
    tick();
    lookupOnly(1'b1, 32'h100);
    midCycle();
    checkOutput("stall_pred_taken", pred_taken, 0);
    checkOutput("stall_next_pc", pred_next_pc, 32'h104);
    checkOutput("stall_br_count", br_count, 8);

    // Same-cycle lookup and allocate at 0x140 (read-before-write).
    tick();
    applyStimulus(1'b1, 32'h140, 1'b1, 1'b0, 32'h140, 1'b1, 32'h400, 1'b0, 32'h0);
    midCycle();
    checkOutput("rbw_same_cycle", pred_taken, 0);
    checkOutput("rbw_same_next_pc", pred_next_pc, 32'h144);
    tick();
    lookupOnly(1'b1, 32'h140);
    midCycle();
    checkOutput("rbw_next_cycle", pred_taken, 1);
    checkOutput("rbw_next_pc", pred_next_pc, 32'h400);
    tick();
    lookupOnly(1'b1, 32'h540);
    midCycle();
    checkOutput("alias_pred_taken", pred_taken, 0);
    checkOutput("alias_next_pc", pred_next_pc, 32'h544);
    tick();
    lookupOnly(1'b0, 32'h140);
    midCycle();
    checkOutput("invalid_lookup", pred_taken, 0);

    // Right direction, wrong target.
    tick();
    applyStimulus(1'b1, 32'h140, 1'b1, 1'b0, 32'h140, 1'b1, 32'h480, 1'b1, 32'h400);
    midCycle();
    checkOutput("tgt_flush", flush, 1);
    checkOutput("tgt_redirect", redirect_pc, 32'h480);
    tick();
    lookupOnly(1'b1, 32'h140);
    midCycle();
    checkOutput("tgt_next_pc", pred_next_pc, 32'h480);

    // Not-taken miss leaves table untouched.
    tick();
    applyStimulus(1'b1, 32'h208, 1'b1, 1'b0, 32'h208, 1'b0, 32'h999, 1'b0, 32'h0);
    midCycle();
    checkOutput("ntmiss_flush", flush, 0);
    checkOutput("ntmiss_redirect", redirect_pc, 32'h20C);
    tick();
    lookupOnly(1'b1, 32'h208);
    midCycle();
    checkOutput("ntmiss_pred", pred_taken, 0);

    // Fall-through wraps at the top of the address space.
    tick();
    lookupOnly(1'b1, 32'hFFFF_FFFC);
    midCycle();
    checkOutput("wrap_next_pc", pred_next_pc, 32'h0);

    // Reset asserted between edges while an update is pending.
    tick();
    applyStimulus(1'b1, 32'h140, 1'b1, 1'b0, 32'h140, 1'b1, 32'h480, 1'b1, 32'h480);
    midCycle();
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pred", pred_taken, 0);
    checkOutput("async_rst_next_pc", pred_next_pc, 32'h144);
    checkOutput("async_rst_br", br_count, 0);
    checkOutput("async_rst_mp", mp_count, 0);
    tick();
    rst = 1'b0;
    lookupOnly(1'b1, 32'h140);
    midCycle();
    checkOutput("post_rst_pred", pred_taken, 0);
    checkOutput("post_rst_br", br_count, 0);
    tick();

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, meaning log2 of table entries (16 entries).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC/target width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock (all state updates on rising edge).
REQ-004 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port if_valid, input, 1, meaning the fetch-stage lookup is valid.
REQ-006 SHALL have port if_pc, input, PC_W, meaning the fetch PC.
REQ-007 SHALL have port pred_taken, output, 1, meaning the predicted-taken flag for if_pc.
REQ-008 SHALL have port pred_next_pc, output, PC_W, meaning the predicted next fetch PC.
REQ-009 SHALL have port ex_branch, input, 1, meaning a conditional branch is resolved in EX this cycle.
REQ-010 SHALL have port ex_stall, input, 1, meaning EX is held, so no update occurs.
REQ-011 SHALL have port ex_pc, input, PC_W, meaning the PC of the resolving branch.
REQ-012 SHALL have port ex_taken, input, 1, meaning the actual outcome (branch control unit branchSignal).
REQ-013 SHALL have port ex_target, input, PC_W, meaning the actual branch target.
REQ-014 SHALL have port ex_pred_taken, input, 1, meaning the prediction carried down the pipeline.
REQ-015 SHALL have port ex_pred_target, input, PC_W, meaning the predicted target carried down the pipeline.
REQ-016 SHALL have port flush, output, 1, meaning mispredict: squash IF/ID and redirect.
REQ-017 SHALL have port redirect_pc, output, PC_W, meaning the correct next PC when flush=1.
REQ-018 SHALL have port br_count, output, 16, meaning resolved branches counted (saturating).
REQ-019 SHALL have port mp_count, output, 16, meaning mispredicts counted (saturating).

Function
REQ-020 SHALL hold 2^IDX_BITS entries, each with valid, tag=PC[PC_W-1:IDX_BITS+2], target, and a 2-bit counter.
REQ-021 SHALL index the table with PC[IDX_BITS+1:2]; hit = valid and tag match.
REQ-022 SHALL encode counter states as SNT=00, WNT=01, WT=10, ST=11.
REQ-023 SHALL drive pred_taken combinationally as if_valid and hit and counter[1], with zero-cycle latency.
REQ-024 SHALL drive pred_next_pc as the entry target when pred_taken=1, else if_pc+4 (modulo 2^PC_W).
REQ-025 SHALL define the update event as ex_branch=1 and ex_stall=0; table and counters change only on that rising edge.
REQ-026 On the update event with a hit, SHALL increment the counter if taken (saturate at ST), decrement it if not taken (saturate at SNT), and overwrite the target if taken.
REQ-027 On the update event with a miss and taken, SHALL allocate the entry: valid=1, new tag, target=ex_target, counter=WT.
REQ-028 On the update event with a miss and not taken, SHALL leave the table unchanged.
REQ-029 SHALL assert flush combinationally when ex_branch=1, ex_stall=0, and either (ex_taken != ex_pred_taken) or (ex_taken=1 and ex_target != ex_pred_target).
REQ-030 SHALL drive redirect_pc as ex_target if ex_taken=1, else ex_pc+4.
REQ-031 On a same-cycle lookup and update to one index, SHALL return the pre-update entry to the lookup (read-before-write).
REQ-032 SHALL increment br_count on each update event and mp_count on each flush; both saturate at 16'hFFFF.

Reset
REQ-033 While rst=1, SHALL clear all valid bits, set all counters to WNT, and clear br_count and mp_count to 0, so that pred_taken=0 and pred_next_pc=if_pc+4.
REQ-034 On reset asserted mid-update, the reset SHALL win and no partial update SHALL persist.

Structure
REQ-035 Package bp_pkg SHALL hold the counter-state constants, IDX_BITS/PC_W defaults, and the entry typedef.
REQ-036 SHALL instantiate one sub-module, sat_counter2, for the 2-bit saturating next-state logic.

Verification
REQ-037 After reset, if_pc=0x100 with if_valid=1 SHALL give pred_taken=0 and pred_next_pc=0x104.
REQ-038 An update with ex_pc=0x100, taken, target 0x200 and pred_taken=0 SHALL give flush=1 and redirect_pc=0x200; the next lookup at 0x100 SHALL give pred_taken=1 and pred_next_pc=0x200.
REQ-039 Three taken updates then four not-taken updates at 0x100 SHALL give counter sequence WT, ST, ST, ST, WT, WNT, SNT, SNT, with prediction 0 after the sixth update.
REQ-040 An update with ex_stall=1 and a mispredicting outcome SHALL give flush=0, an unchanged table, and unchanged br_count.
REQ-041 Same-cycle lookup and allocate at 0x140 SHALL give pred_taken=0 that cycle and 1 the next cycle; an alias at 0x540 (same index, different tag) SHALL then miss.
REQ-042 Asserting rst between update cycles SHALL zero the counters and invalidate all entries immediately, asynchronously to clk.
